pwm_cfg_update_ctrl: RTL and testbench
======================================

Name: pwm_cfg_update_ctrl

Overview:
Shadow-register update controller for one PWM carrier/comparator channel. It accepts a new configuration through a valid/ready handshake and holds it in shadow registers. It commits the configuration to the active outputs only at safe carrier events selected by the active mask mode, so period and compare changes never glitch mid-cycle. It sits between the register/config interface and the carrier counter, and issues a counter restart when the counting scheme changes.

Parameters:
CNT_W, 16, width of period and compare values
SKIP_W, 4, width of the update-event skip counter
PERIOD_RST, 1000, act_period value after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  controller can accept a configuration
cfg_period  in  CNT_W  requested carrier period
cfg_compare  in  CNT_W  requested compare value
cfg_count_mode  in  2  requested _count_mode (COUNT_UP=0, COUNT_DOWN=1, COUNT_UPDOWN=2)
cfg_mask_mode  in  2  requested _mask_mode (NO_MASK=0, MIN_MASK=1, MAX_MASK=2, MINMAX_MASK=3)
cfg_onoff  in  1  requested _pwm_onoff (PWM_OFF=0, PWM_ON=1)
cfg_skip  in  SKIP_W  number of eligible events to skip before commit
cfg_abort  in  1  discard the pending configuration
ev_min  in  1  carrier-at-minimum pulse from the counter
ev_max  in  1  carrier-at-maximum pulse from the counter
act_period  out  CNT_W  active period
act_compare  out  CNT_W  active compare
act_count_mode  out  2  active count mode
act_mask_mode  out  2  active mask mode
act_onoff  out  1  active on/off
cnt_restart  out  1  one-cycle counter restart request
commit_pulse  out  1  one-cycle commit strobe
busy  out  1  configuration pending

Behaviour:
- Reset, asynchronous, all outputs:
  - act_period=PERIOD_RST, act_compare=0, act_count_mode=COUNT_UP, act_mask_mode=NO_MASK, act_onoff=PWM_OFF
  - cfg_ready=1, busy=0, cnt_restart=0, commit_pulse=0
  - Any pending shadow configuration is discarded; the FSM enters IDLE.
- FSM states: IDLE, PENDING, COMMIT.
- IDLE:
  - cfg_ready=1.
  - cfg_valid&&cfg_ready latches all cfg_* fields into the shadow registers and loads skip_cnt=cfg_skip.
  - Next state is PENDING; cfg_ready=0 and busy=1 from the following cycle.
- PENDING:
  - Eligibility is decided by the ACTIVE mask mode:
    - NO_MASK: every cycle is eligible.
    - MIN_MASK: ev_min.
    - MAX_MASK: ev_max.
    - MINMAX_MASK: ev_min|ev_max.
  - ev_min and ev_max in the same cycle count as one eligible event.
  - Eligible event with skip_cnt>0: decrement skip_cnt and stay in PENDING.
  - Eligible event with skip_cnt==0: go to COMMIT.
- Fast-off: if shadow onoff==PWM_OFF, go to COMMIT on the first PENDING cycle, ignoring mask and skip.
- cfg_abort in PENDING: return to IDLE with no commit and no change to act_*. cfg_abort has priority over an eligible event in the same cycle, and is ignored in IDLE and COMMIT.
- COMMIT (one cycle):
  - act_* registers load the shadow values at the entry edge. Latency: eligible event at cycle N gives new act_* and commit_pulse=1 at cycle N+1.
  - cnt_restart=1 in the same cycle if act_count_mode changed, or act_onoff went PWM_OFF->PWM_ON.
  - Next state is IDLE; cfg_ready=1 at N+2.
- Commit sanitising rules:
  - cfg_count_mode=2'b11 commits as COUNT_UP.
  - compare>period commits act_compare=period.
  - period==0 commits act_onoff=PWM_OFF regardless of the request.
- skip_cnt wraps never; it saturates at 0.
- cfg_valid while busy is ignored (no latch) until cfg_ready returns.

Optional Feature:
PWM_UPD_IRQ_EN
- Defined:
  - Adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is a sticky flag set on every commit_pulse and cleared by irq_clr; set wins when both occur in the same cycle.
  - irq resets to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- After reset, check act_period=1000, act_onoff=PWM_OFF, cfg_ready=1. Send period=500, compare=200, mask NO_MASK, onoff ON, skip=0 at cycle 0 -> commit_pulse at cycle 2, act_period=500, act_compare=200, cnt_restart=1 (OFF->ON).
- With act_mask_mode=MAX_MASK, send cfg skip=2 -> commit occurs exactly one cycle after the third ev_max pulse; ev_min pulses are ignored.
- While PENDING, send cfg onoff=PWM_OFF with mask MIN_MASK and skip=5 -> fast-off commit one cycle after PENDING entry, with no ev_min needed.
- Send compare=700 with period=300 -> act_compare=300. Send period=0, onoff ON -> act_onoff=PWM_OFF. Send count_mode=3 -> act_count_mode=COUNT_UP, with cnt_restart only if the previous mode differed.
- Assert cfg_abort in the same cycle as an eligible ev_min -> no commit_pulse, act_* unchanged, cfg_ready=1 next cycle. Assert rst mid-PENDING -> all outputs return to reset values immediately.
- With PWM_UPD_IRQ_EN: after a commit, irq=1 until irq_clr. irq_clr coincident with a new commit_pulse -> irq stays 1.

Source files
------------

// File: rtl/pwm_cfg_update_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_cfg_update_ctrl
//
// Shadow-register update controller for one PWM carrier/comparator channel.
// A new configuration is accepted over a valid/ready handshake into shadow
// registers. It is copied to the active outputs only on a safe carrier event
// chosen by the currently active mask mode. This means period and compare
// values never change part-way through a carrier cycle. When the counting
// scheme changes, the controller asks the counter to restart.
//
// Optional feature macro: PWM_UPD_IRQ_EN
//   When defined, this adds a sticky irq output that is set on every commit
//   and cleared by irq_clr. If set and clear occur in the same cycle, set wins.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid/ready   configuration handshake
//   cfg_period        requested carrier period
//   cfg_compare       requested compare value
//   cfg_count_mode    0=up, 1=down, 2=up/down (3 is treated as up)
//   cfg_mask_mode     0=none, 1=min, 2=max, 3=min|max
//   cfg_onoff         requested on/off
//   cfg_skip          number of eligible events to skip before the commit
//   cfg_abort         drop the pending configuration
//   ev_min, ev_max    carrier extreme pulses from the counter
//   act_*             active configuration seen by the carrier/comparator
//   cnt_restart       one-cycle counter restart request (with commit)
//   commit_pulse      one-cycle strobe in the cycle new act_* appear
//   busy              a configuration is in flight
//   irq, irq_clr      sticky commit flag and its clear (PWM_UPD_IRQ_EN only)
// ---------------------------------------------------------------------------
module pwm_cfg_update_ctrl #(
   parameter int CNT_W      = 16,
   parameter int SKIP_W     = 4,
   parameter int PERIOD_RST = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_compare,
   input  logic [1:0]        cfg_count_mode,
   input  logic [1:0]        cfg_mask_mode,
   input  logic              cfg_onoff,
   input  logic [SKIP_W-1:0] cfg_skip,
   input  logic              cfg_abort,
   input  logic              ev_min,
   input  logic              ev_max,
   output logic [CNT_W-1:0]  act_period,
   output logic [CNT_W-1:0]  act_compare,
   output logic [1:0]        act_count_mode,
   output logic [1:0]        act_mask_mode,
   output logic              act_onoff,
   output logic              cnt_restart,
   output logic              commit_pulse,
   output logic              busy
`ifdef PWM_UPD_IRQ_EN
   ,
   output logic              irq,
   input  logic              irq_clr
`endif
);

   localparam logic [1:0] COUNT_UP    = 2'd0;
   localparam logic [1:0] NO_MASK     = 2'd0;
   localparam logic [1:0] MIN_MASK    = 2'd1;
   localparam logic [1:0] MAX_MASK    = 2'd2;
   localparam logic       PWM_OFF     = 1'b0;
   localparam logic       PWM_ON      = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_COMMIT
   } state_t;

   state_t state, next_state;

   logic [CNT_W-1:0]  sh_period;
   logic [CNT_W-1:0]  sh_compare;
   logic [1:0]        sh_count_mode;
   logic [1:0]        sh_mask_mode;
   logic              sh_onoff;
   logic [SKIP_W-1:0] skip_cnt;

   logic              load;
   logic              skip_dec;
   logic              do_commit;
   logic              eligible;

   logic [CNT_W-1:0]  new_compare;
   logic [1:0]        new_count_mode;
   logic              new_onoff;

   // The reserved count-mode encoding falls back to plain up-counting.
   function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
      return (mode == 2'b11) ? COUNT_UP : mode;
   endfunction

   // A compare value above the period would never match, so it is clamped.
   function automatic logic [CNT_W-1:0] clamp_compare(input logic [CNT_W-1:0] cmp,
                                                      input logic [CNT_W-1:0] per);
      return (cmp > per) ? per : cmp;
   endfunction

   assign new_compare    = clamp_compare(sh_compare, sh_period);
   assign new_count_mode = sanitize_mode(sh_count_mode);
   // A zero period cannot run a carrier, so the channel is forced off.
   assign new_onoff      = (sh_period == '0) ? PWM_OFF : sh_onoff;

   // Eligibility follows the mask that is currently active, not the one being
   // installed. Simultaneous min and max pulses count as a single event.
   always_comb begin
      eligible = 1'b0;
      case (act_mask_mode)
         NO_MASK:  eligible = 1'b1;
         MIN_MASK: eligible = ev_min;
         MAX_MASK: eligible = ev_max;
         default:  eligible = ev_min | ev_max;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      cfg_ready  = 1'b0;
      busy       = 1'b0;
      load       = 1'b0;
      skip_dec   = 1'b0;
      do_commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               load       = 1'b1;
               next_state = ST_PENDING;
            end
         end
         ST_PENDING: begin
            busy = 1'b1;
            if (cfg_abort) begin
               next_state = ST_IDLE;
            end else if (sh_onoff == PWM_OFF) begin
               // Switching off is always safe, so there is no need to wait for an event.
               do_commit  = 1'b1;
               next_state = ST_COMMIT;
            end else if (eligible) begin
               if (skip_cnt != '0) begin
                  skip_dec = 1'b1;
               end else begin
                  do_commit  = 1'b1;
                  next_state = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: begin
            busy       = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign commit_pulse = (state == ST_COMMIT);

   // Shadow data needs no reset: it is always written before it is read.
   always_ff @(posedge clk) begin
      if (load) begin
         sh_period     <= cfg_period;
         sh_compare    <= cfg_compare;
         sh_count_mode <= cfg_count_mode;
         sh_mask_mode  <= cfg_mask_mode;
         sh_onoff      <= cfg_onoff;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skip_cnt <= '0;
      end else if (load) begin
         skip_cnt <= cfg_skip;
      end else if (skip_dec) begin
         skip_cnt <= skip_cnt - SKIP_W'(1);
      end
   end

   // Active registers load on the edge that enters COMMIT. The restart
   // decision compares against the values being replaced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_period     <= CNT_W'(PERIOD_RST);
         act_compare    <= '0;
         act_count_mode <= COUNT_UP;
         act_mask_mode  <= NO_MASK;
         act_onoff      <= PWM_OFF;
         cnt_restart    <= 1'b0;
      end else if (do_commit) begin
         act_period     <= sh_period;
         act_compare    <= new_compare;
         act_count_mode <= new_count_mode;
         act_mask_mode  <= sh_mask_mode;
         act_onoff      <= new_onoff;
         cnt_restart    <= (new_count_mode != act_count_mode) ||
                           ((act_onoff == PWM_OFF) && (new_onoff == PWM_ON));
      end else begin
         cnt_restart    <= 1'b0;
      end
   end

`ifdef PWM_UPD_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               irq <= 1'b0;
      else if (commit_pulse) irq <= 1'b1;
      else if (irq_clr)      irq <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_pwm_cfg_update_ctrl.sv
module tb_pwm_cfg_update_ctrl;

   localparam int L = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [15:0] cfg_period = '0;
   logic [15:0] cfg_compare = '0;
   logic [1:0]  cfg_count_mode = '0;
   logic [1:0]  cfg_mask_mode = '0;
   logic        cfg_onoff = 1'b0;
   logic [3:0]  cfg_skip = '0;
   logic        cfg_abort = 1'b0;
   logic        ev_min = 1'b0;
   logic        ev_max = 1'b0;
   logic [15:0] act_period;
   logic [15:0] act_compare;
   logic [1:0]  act_count_mode;
   logic [1:0]  act_mask_mode;
   logic        act_onoff;
   logic        cnt_restart;
   logic        commit_pulse;
   logic        busy;
`ifdef PWM_UPD_IRQ_EN
   logic        irq;
   logic        irq_clr = 1'b0;
`endif

   pwm_cfg_update_ctrl #(.CNT_W(16), .SKIP_W(4), .PERIOD_RST(1000)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_compare(cfg_compare),
      .cfg_count_mode(cfg_count_mode), .cfg_mask_mode(cfg_mask_mode),
      .cfg_onoff(cfg_onoff), .cfg_skip(cfg_skip), .cfg_abort(cfg_abort),
      .ev_min(ev_min), .ev_max(ev_max),
      .act_period(act_period), .act_compare(act_compare),
      .act_count_mode(act_count_mode), .act_mask_mode(act_mask_mode),
      .act_onoff(act_onoff), .cnt_restart(cnt_restart),
      .commit_pulse(commit_pulse), .busy(busy)
`ifdef PWM_UPD_IRQ_EN
      , .irq(irq), .irq_clr(irq_clr)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   typedef struct {
      bit          committed;
      int          end_cyc;
      logic [15:0] per;
      logic [15:0] cmp;
      logic [1:0]  mode;
      logic [1:0]  mask;
      logic        onoff;
      logic        restart;
   } exp_t;

   exp_t exp_q[$];

   // Reference view of the active configuration.
   logic [15:0] m_per = 16'd1000;
   logic [15:0] m_cmp = '0;
   logic [1:0]  m_mode = '0;
   logic [1:0]  m_mask = '0;
   logic        m_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, required, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_act_period"}, act_period, 1000);
      chk({tag, "_act_compare"}, act_compare, 0);
      chk({tag, "_act_count_mode"}, act_count_mode, 0);
      chk({tag, "_act_mask_mode"}, act_mask_mode, 0);
      chk({tag, "_act_onoff"}, act_onoff, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cnt_restart"}, cnt_restart, 0);
      chk({tag, "_commit_pulse"}, commit_pulse, 0);
   endtask

   // Starts and ends at a negative edge. The expected outcome is computed
   // up front: walk the planned event stream, count eligible events under the
   // mask active before this transaction, and see whether the abort or the
   // (skip+1)-th eligible event comes first.
   task automatic run_txn(input logic [15:0] p, input logic [15:0] c, input logic [1:0] mode,
                          input logic [1:0] mask, input logic on, input logic [3:0] sk,
                          input bit ab_en, input int ab_at);
      bit   pmin[L];
      bit   pmax[L];
      exp_t e;
      int   end_off;
      int   last_pend;
      int   seen;
      int   w;
      bit   emin, emax, elig, done;
      logic [1:0] nm;
      logic       non;

      w = 0;
      while (!cfg_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait_bound", (w < 200), 1);

      for (int i = 0; i < L; i++) begin
         pmin[i] = ($urandom_range(0, 99) < 30);
         pmax[i] = ($urandom_range(0, 99) < 30);
      end
      if (ab_en && ab_at < L) pmin[ab_at] = 1'b1;

      seen    = 0;
      done    = 1'b0;
      end_off = 0;
      e.committed = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         emin = (k < L) ? pmin[k] : 1'b1;
         emax = (k < L) ? pmax[k] : 1'b1;
         case (m_mask)
            2'd0:    elig = 1'b1;
            2'd1:    elig = emin;
            2'd2:    elig = emax;
            default: elig = emin | emax;
         endcase
         if (ab_en && k == ab_at) begin
            end_off = k + 1;
            done    = 1'b1;
         end else if (!on || (elig && seen == int'(sk))) begin
            e.committed = 1'b1;
            end_off = k + 2;
            done    = 1'b1;
         end else if (elig) begin
            seen++;
         end
      end
      last_pend = e.committed ? end_off - 2 : end_off - 1;

      if (e.committed) begin
         nm  = (mode == 2'b11) ? 2'b00 : mode;
         non = (p == 0) ? 1'b0 : on;
         e.restart = (nm != m_mode) || (!m_on && non);
         m_per  = p;
         m_cmp  = (c > p) ? p : c;
         m_mode = nm;
         m_mask = mask;
         m_on   = non;
      end else begin
         e.restart = 1'b0;
      end
      e.per = m_per; e.cmp = m_cmp; e.mode = m_mode; e.mask = m_mask; e.onoff = m_on;
      e.end_cyc = cyc + 1 + end_off;
      exp_q.push_back(e);

      cfg_valid      = 1'b1;
      cfg_period     = p;
      cfg_compare    = c;
      cfg_count_mode = mode;
      cfg_mask_mode  = mask;
      cfg_onoff      = on;
      cfg_skip       = sk;
      cfg_abort      = 1'($urandom_range(0, 1));
      ev_min         = 1'($urandom_range(0, 1));
      ev_max         = 1'($urandom_range(0, 1));
      @(negedge clk);

      for (int k = 0; k < 400; k++) begin
         if (cfg_ready) break;
         // Offers made while busy must be ignored.
         cfg_valid      = 1'($urandom_range(0, 1));
         cfg_period     = 16'($urandom);
         cfg_compare    = 16'($urandom);
         cfg_count_mode = 2'($urandom);
         cfg_mask_mode  = 2'($urandom);
         cfg_onoff      = 1'($urandom);
         cfg_skip       = 4'($urandom);
         ev_min         = (k < L) ? pmin[k] : 1'b1;
         ev_max         = (k < L) ? pmax[k] : 1'b1;
         cfg_abort      = (ab_en && k == ab_at) ||
                          (k > last_pend && $urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      ev_min    = 1'b0;
      ev_max    = 1'b0;
   endtask

   // Monitor: every return of cfg_ready closes one transaction.
   bit prev_ready = 1'b1;
   bit seen_commit = 1'b0;
   bit seen_restart = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!mon_en || rst) begin
            prev_ready   = cfg_ready;
            seen_commit  = 1'b0;
            seen_restart = 1'b0;
         end else begin
            chk("restart_without_commit", cnt_restart & ~commit_pulse, 0);
            if (commit_pulse) begin
               seen_commit  = 1'b1;
               seen_restart = cnt_restart;
            end
            if (cfg_ready && !prev_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_txn_end", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("committed", seen_commit, e.committed);
                  chk("end_cycle", cyc, e.end_cyc);
                  chk("act_period", act_period, e.per);
                  chk("act_compare", act_compare, e.cmp);
                  chk("act_count_mode", act_count_mode, e.mode);
                  chk("act_mask_mode", act_mask_mode, e.mask);
                  chk("act_onoff", act_onoff, e.onoff);
                  if (e.committed) chk("cnt_restart", seen_restart, e.restart);
               end
               seen_commit  = 1'b0;
               seen_restart = 1'b0;
            end
            prev_ready = cfg_ready;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] p;
      repeat (3) @(negedge clk);
      #1 chk_reset_outputs("in_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("post_reset");
      mon_en = 1'b1;

      // Directed cases from the plan.
      run_txn(16'd500, 16'd200, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 0);
      run_txn(16'd500, 16'd100, 2'd0, 2'd2, 1'b1, 4'd0, 1'b0, 0);
      run_txn(16'd400, 16'd100, 2'd1, 2'd2, 1'b1, 4'd2, 1'b0, 0);
      run_txn(16'd300, 16'd10,  2'd1, 2'd1, 1'b0, 4'd5, 1'b0, 0);
      run_txn(16'd300, 16'd700, 2'd1, 2'd0, 1'b1, 4'd0, 1'b0, 0);
      run_txn(16'd0,   16'd5,   2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 0);
      run_txn(16'd200, 16'd50,  2'd3, 2'd1, 1'b1, 4'd1, 1'b0, 0);
      run_txn(16'd200, 16'd50,  2'd2, 2'd1, 1'b1, 4'd0, 1'b1, 0);
      run_txn(16'd250, 16'd60,  2'd3, 2'd3, 1'b1, 4'd1, 1'b0, 0);

      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(0, 3))
            0:       p = 16'd0;
            1:       p = 16'($urandom_range(1, 20));
            default: p = 16'($urandom);
         endcase
         run_txn(p, 16'($urandom_range(0, 40)) + ($urandom_range(0, 1) ? p : 16'd0),
                 2'($urandom), 2'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 15), $urandom_range(0, L - 1));
      end

      // Reset in the middle of a pending transaction.
      @(negedge clk);
      mon_en = 1'b0;
      while (!cfg_ready) @(negedge clk);
      cfg_valid = 1'b1; cfg_period = 16'd100; cfg_compare = 16'd10;
      cfg_count_mode = 2'd2; cfg_mask_mode = 2'd1; cfg_onoff = 1'b1; cfg_skip = 4'd15;
      @(negedge clk);
      cfg_valid = 1'b0; ev_min = 1'b0; ev_max = 1'b0;
      @(negedge clk);
      chk("midpending_busy", busy, 1);
      rst = 1'b1;
      #1 chk_reset_outputs("mid_pending_reset");
      @(negedge clk);
      rst = 1'b0;
      m_per = 16'd1000; m_cmp = '0; m_mode = '0; m_mask = '0; m_on = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      run_txn(16'd500, 16'd200, 2'd0, 2'd0, 1'b1, 4'd0, 1'b0, 0);

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
